// File: rtl/ssd_share_arbiter.sv
// Two-channel round-robin owner of the 4-digit seven-segment display.
// Each contended grant is held for at least HOLD_CYCLES; display data is registered from the next owner.
module ssd_share_arbiter #(
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int CNT_W       = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [15:0] val0,
  input  logic        req1,
  input  logic [15:0] val1,
  input  logic        lz_blank,
  output logic        gnt0,
  output logic        gnt1,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic [3:0]  mode
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0][3:0]   dig_q, dig_d;
  logic [3:0]        mode_q, mode_d;

  logic              expired;
  logic              entering;
  logic [15:0]       val_sel;
  logic [3:0]        lz_mode;

  assign expired = (cnt_q == HOLD_MAX);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = rr_q ? OWN1 : OWN0;
        else if (req0)     state_d = OWN0;
        else if (req1)     state_d = OWN1;
      end
      OWN0: begin
        if (!req0)                state_d = req1 ? OWN1 : IDLE;
        else if (expired && req1) state_d = OWN1;
      end
      OWN1: begin
        if (!req1)                state_d = req0 ? OWN0 : IDLE;
        else if (expired && req0) state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase
  end

  // A switch between owners counts as a fresh entry, so the hold restarts.
  assign entering = (state_d != IDLE) && (state_d != state_q);

  always_comb begin
    rr_d  = rr_q;
    cnt_d = cnt_q;
    if (entering) begin
      cnt_d = '0;
      rr_d  = (state_d == OWN0);
    end else if (state_d == IDLE) begin
      cnt_d = '0;
    end else if (!expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    val_sel = 16'h0000;
    if (state_d == OWN0)      val_sel = val0;
    else if (state_d == OWN1) val_sel = val1;
  end

  // Digit n lights when any nibble at or above it is nonzero; digit 0 always lights.
  assign lz_mode[0] = 1'b1;
  for (genvar n = 1; n < 4; n++) begin : g_lz
    assign lz_mode[n] = |val_sel[15:4*n];
  end

  always_comb begin
    dig_d  = val_sel;
    mode_d = 4'b0000;
    if (state_d != IDLE) mode_d = lz_blank ? lz_mode : 4'b1111;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      dig_q   <= '0;
      mode_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      mode_q  <= mode_d;
    end
  end

  assign gnt0   = (state_q == OWN0);
  assign gnt1   = (state_q == OWN1);
  assign digit0 = dig_q[0];
  assign digit1 = dig_q[1];
  assign digit2 = dig_q[2];
  assign digit3 = dig_q[3];
  assign mode   = mode_q;

endmodule

// File: tb/tb_ssd_share_arbiter.sv
// Bench for ssd_share_arbiter with HOLD_CYCLES=4: directed sequences, a mode table and random traffic.
module tb_ssd_share_arbiter;

  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, lz = 1'b0;
  logic [15:0] v0 = 16'h0, v1 = 16'h0;
  logic        gnt0, gnt1;
  logic [3:0]  digit0, digit1, digit2, digit3, mode;

  int checks = 0;
  int failures = 0;

  ssd_share_arbiter #(.HOLD_CYCLES(H), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .val0(v0), .req1(req1), .val1(v1), .lz_blank(lz),
    .gnt0(gnt0), .gnt1(gnt1),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .mode(mode)
  );

  always #5 clk = ~clk;

  // Reference: current owner (-1 none), cycles already owned, preferred channel on a tie.
  int          m_own = -1;
  int          m_age = 0;
  int          m_pref = 0;
  logic        e_g0 = 0, e_g1 = 0;
  logic [3:0]  e_mode = 0;
  logic [15:0] e_dig = 0;

  function automatic logic [3:0] ref_mode(logic [15:0] v, logic blank);
    int top = 0;
    for (int i = 0; i < 4; i++)
      if (((v >> (4 * i)) & 16'hF) != 0) top = i;
    return blank ? 4'((1 << (top + 1)) - 1) : 4'hF;
  endfunction

  function automatic void model_reset();
    m_own = -1; m_age = 0; m_pref = 0;
    e_g0 = 0; e_g1 = 0; e_mode = 0; e_dig = 0;
  endfunction

  function automatic void model_step();
    logic r [2];
    int nxt, j;
    r[0] = req0; r[1] = req1;
    nxt = m_own;
    if (m_own < 0) begin
      if (r[0] && r[1]) nxt = m_pref;
      else if (r[0])    nxt = 0;
      else if (r[1])    nxt = 1;
    end else begin
      j = 1 - m_own;
      if (!r[m_own])                  nxt = r[j] ? j : -1;
      else if (m_age >= H - 1 && r[j]) nxt = j;
    end
    if (nxt >= 0 && nxt != m_own) begin
      m_age = 0; m_pref = 1 - nxt;
    end else if (nxt >= 0) begin
      m_age = (m_age + 1 > H - 1) ? H - 1 : m_age + 1;
    end else begin
      m_age = 0;
    end
    m_own = nxt;
    e_g0 = (nxt == 0);
    e_g1 = (nxt == 1);
    e_dig  = (nxt == 0) ? v0 : (nxt == 1) ? v1 : 16'h0;
    e_mode = (nxt < 0) ? 4'h0 : ref_mode(e_dig, lz);
  endfunction

  task automatic cmp(string nm);
    checks++;
    if ({gnt0, gnt1, mode, digit3, digit2, digit1, digit0} !== {e_g0, e_g1, e_mode, e_dig}) begin
      failures++;
      $display("FAIL %s: got g0=%b g1=%b mode=%b dig=%h%h%h%h, want g0=%b g1=%b mode=%b dig=%h",
               nm, gnt0, gnt1, mode, digit3, digit2, digit1, digit0, e_g0, e_g1, e_mode, e_dig);
    end
    checks++;
    if (gnt0 && gnt1) begin
      failures++;
      $display("FAIL %s_both_gnt: got 11, want at most one grant", nm);
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(string nm);
    @(posedge clk);
    model_step();
    #1;
    cmp(nm);
  endtask

  typedef struct {
    logic [15:0] val;
    logic        blank;
    logic [3:0]  mode;
  } vec_t;
  vec_t tbl [8];

  initial begin
    tbl[0] = '{16'h0000, 1'b1, 4'b0001};
    tbl[1] = '{16'h0007, 1'b1, 4'b0001};
    tbl[2] = '{16'h00A0, 1'b1, 4'b0011};
    tbl[3] = '{16'h0300, 1'b1, 4'b0111};
    tbl[4] = '{16'hF000, 1'b1, 4'b1111};
    tbl[5] = '{16'h0000, 1'b0, 4'b1111};
    tbl[6] = '{16'h0A05, 1'b1, 4'b0111};
    tbl[7] = '{16'h1000, 1'b1, 4'b1111};

    // Reset state
    model_reset();
    #12;
    cmp("reset_state");
    rst = 1'b1;

    // 1: async reset while OWN0, then ch1 takes the display
    req0 = 1; v0 = 16'hBEEF;
    tick("own0_before_reset");
    tick("own0_hold");
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    cmp("async_reset_drop");
    req0 = 0; req1 = 1; v1 = 16'h1234; lz = 0;
    #3;
    rst = 1'b1;
    tick("post_reset_gnt1");
    chk("post_reset_digits", {digit3, digit2, digit1, digit0}, 16'h1234);
    chk("post_reset_mode", mode, 4'b1111);
    req1 = 0;
    tick("release_to_idle");

    // 2: contention from IDLE after reset (rr=0): 4 cycles each, alternating
    rst = 1'b0; #1; model_reset(); #3; rst = 1'b1;
    req0 = 1; req1 = 1; v0 = 16'h0AAA; v1 = 16'h0BBB;
    for (int c = 0; c < 12; c++) begin
      tick("contend");
      chk("contend_gnt0", gnt0, ((c / H) % 2 == 0) ? 1 : 0);
      chk("contend_gnt1", gnt1, ((c / H) % 2 == 1) ? 1 : 0);
    end
    req0 = 0; req1 = 0;
    tick("contend_release");

    // 3: owner drops as other requests, no idle gap, hold restarts
    req0 = 1;
    tick("own0_cnt0");
    tick("own0_cnt1");
    req0 = 0; req1 = 1;
    tick("direct_switch");
    chk("direct_switch_gnt1", gnt1, 1);
    req0 = 1;
    for (int c = 0; c < H; c++) begin
      tick("restart_hold");
      chk("restart_hold_gnt1", gnt1, (c < H - 1) ? 1 : 0);
    end
    req0 = 0;

    // 4: uncontended ch1 keeps the display, then release darkens it
    for (int c = 0; c < 20; c++) tick("uncontended");
    chk("uncontended_gnt1", gnt1, 1);
    req1 = 0;
    tick("release_dark");
    chk("release_mode", mode, 4'b0000);

    // 5: leading-zero blanking table
    req0 = 1;
    tick("own0_for_table");
    foreach (tbl[i]) begin
      v0 = tbl[i].val; lz = tbl[i].blank;
      tick("lz_table");
      chk("lz_table_mode", mode, tbl[i].mode);
      chk("lz_table_digits", {digit3, digit2, digit1, digit0}, tbl[i].val);
    end

    // 6: ch0 was last owner, so a tie from IDLE goes to ch1
    req0 = 0;
    tick("idle_before_tie");
    req0 = 1; req1 = 1;
    tick("tie_after_ch0");
    chk("tie_gnt1", gnt1, 1);
    req0 = 0; req1 = 0;
    tick("tie_release");

    // Random traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
      if ($urandom_range(0, 2) == 0) v0 = 16'($urandom) >> (4 * $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) v1 = 16'($urandom) >> (4 * $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) lz = ~lz;
      tick("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
